// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem requests along the predicted path,
// tracks them in an in-flight FIFO and buffers in-order responses for decode.
module fetch_ctrl #(
    parameter logic [47:0] RESET_PC        = 48'h0,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        redirect,
    input  logic [47:0] redirect_pc,
    input  logic        pred_valid,
    input  logic [47:0] pred_pc,
    output logic        imem_req_valid,
    output logic [47:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    output logic [47:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int FW = $clog2(FQ_DEPTH);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int IC = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + FQ_DEPTH + 1);
    localparam logic [47:0] ALIGN_MASK = ~48'h3;

    logic [47:0]          pc_reg;
    logic                 epoch_reg;

    logic [47:0]          if_pc    [MAX_OUTSTANDING];
    logic                 if_epoch [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] if_stale_reg;
    logic [IW-1:0]        if_wr_reg;
    logic [IW-1:0]        if_rd_reg;
    logic [IC-1:0]        if_count_reg;

    logic [47:0]          fq_pc    [FQ_DEPTH];
    logic [31:0]          fq_instr [FQ_DEPTH];
    logic [FW-1:0]        fq_wr_reg;
    logic [FW-1:0]        fq_rd_reg;
    logic [FW:0]          fq_count_reg;

    logic [CW-1:0]        credit_used;
    logic                 accept;
    logic                 rsp_pop;
    logic                 fq_push;
    logic                 fq_pop;
    logic [47:0]          pc_next;

    // Credit counts both in-flight requests and buffered instructions, so every
    // accepted request is guaranteed a fetch-queue slot when it returns.
    assign credit_used    = CW'(if_count_reg) + CW'(fq_count_reg);
    assign imem_req_valid = n_reset && !redirect
                            && (if_count_reg < IC'(MAX_OUTSTANDING))
                            && (credit_used < CW'(FQ_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_pop = imem_rsp_valid && (if_count_reg != '0);
    // The stale bit catches requests that outlive two redirects, which the
    // one-bit epoch alone would alias.
    assign fq_push = rsp_pop && !redirect && !if_stale_reg[if_rd_reg]
                     && (if_epoch[if_rd_reg] == epoch_reg);
    assign fq_pop  = out_valid && out_ready && !redirect;

    assign out_valid = (fq_count_reg != '0);
    assign out_pc    = out_valid ? fq_pc[fq_rd_reg]    : 48'h0;
    assign out_instr = out_valid ? fq_instr[fq_rd_reg] : 32'h0;

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = redirect_pc & ALIGN_MASK;
        end else if (accept) begin
            pc_next = pred_valid ? (pred_pc & ALIGN_MASK) : (pc_reg + 48'd4);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc_reg    <= RESET_PC & ALIGN_MASK;
            epoch_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (redirect) begin
                epoch_reg <= ~epoch_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            if_wr_reg    <= '0;
            if_rd_reg    <= '0;
            if_count_reg <= '0;
            if_stale_reg <= '0;
        end else begin
            if (redirect) begin
                if_stale_reg <= '1;
            end else if (accept) begin
                if_stale_reg[if_wr_reg] <= 1'b0;
            end
            if (accept) begin
                if_wr_reg <= (if_wr_reg == IW'(MAX_OUTSTANDING - 1)) ? '0 : if_wr_reg + 1'b1;
            end
            if (rsp_pop) begin
                if_rd_reg <= (if_rd_reg == IW'(MAX_OUTSTANDING - 1)) ? '0 : if_rd_reg + 1'b1;
            end
            case ({accept, rsp_pop})
                2'b10:   if_count_reg <= if_count_reg + 1'b1;
                2'b01:   if_count_reg <= if_count_reg - 1'b1;
                default: if_count_reg <= if_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fq_wr_reg    <= '0;
            fq_rd_reg    <= '0;
            fq_count_reg <= '0;
        end else if (redirect) begin
            fq_wr_reg    <= '0;
            fq_rd_reg    <= '0;
            fq_count_reg <= '0;
        end else begin
            if (fq_push) begin
                fq_wr_reg <= fq_wr_reg + 1'b1;
            end
            if (fq_pop) begin
                fq_rd_reg <= fq_rd_reg + 1'b1;
            end
            case ({fq_push, fq_pop})
                2'b10:   fq_count_reg <= fq_count_reg + 1'b1;
                2'b01:   fq_count_reg <= fq_count_reg - 1'b1;
                default: fq_count_reg <= fq_count_reg;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy counters qualify every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            if_pc[if_wr_reg]    <= pc_reg;
            if_epoch[if_wr_reg] <= epoch_reg;
        end
        if (fq_push) begin
            fq_pc[fq_wr_reg]    <= if_pc[if_rd_reg];
            fq_instr[fq_wr_reg] <= imem_rsp_data;
        end
    end
endmodule
